tdm_burst_scheduler: RTL and testbench

Time-division slot scheduler for the data-burst path. It divides time into fixed-length slots and assigns each slot round-robin to one of NUM_CH requesters. In each slot it grants at most one bounded burst to the slot owner and reports the burst length and how the burst ended. It sits between the per-channel burst sources and the shared burst datapath, and its slot timer is a down-counter that reloads at zero.

---
 rtl/tdm_burst_scheduler.sv | 172 +++++++++++++++++
 tb/tb_tdm_burst_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_burst_scheduler.sv
//==============================================================================
// Module : tdm_burst_scheduler
// Brief  : Round-robin TDM slot scheduler granting one bounded burst per slot.
//          Define TDM_SKIP_IDLE_EN to end idle slots right after the guard time.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tdm_burst_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int SLOT_LEN  = 255,
    parameter int BURST_MAX = 16,
    parameter int GUARD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            req,
    input  logic                         beat,
    output logic [NUM_CH-1:0]            gnt,
    output logic [$clog2(NUM_CH)-1:0]    slot_idx,
    output logic                         slot_start,
    output logic                         burst_done,
    output logic [$clog2(BURST_MAX):0]   burst_len,
    output logic                         burst_trunc
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(SLOT_LEN + 1);
    localparam int LW = $clog2(BURST_MAX) + 1;

    localparam logic [CW-1:0] CNT_RELOAD = CW'(SLOT_LEN);
    localparam logic [CW-1:0] CNT_ARM    = CW'(SLOT_LEN - GUARD + 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CH - 1);
    localparam logic [LW-1:0] LEN_MAX    = LW'(BURST_MAX);

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // With a one-cycle guard the decision point is cycle 0 itself.
    localparam state_t ST_FIRST = (CNT_RELOAD == CNT_ARM) ? ST_ARMED : ST_GUARD;

    state_t              state_q, state_d;
    logic [CW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]       slot_idx_q, slot_idx_d;
    logic [LW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic                slot_start_q, slot_start_d;
    logic                burst_done_q, burst_done_d;
    logic [LW-1:0]       burst_len_q, burst_len_d;
    logic                burst_trunc_q, burst_trunc_d;

    logic [NUM_CH-1:0]   w_owner;
    logic                w_req_own;
    logic                w_slot_end;
    logic                w_beat_hit;
    logic [LW-1:0]       w_beat_total;
    logic                w_hit_max;
    logic [IW-1:0]       w_idx_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_owner
        assign w_owner[i] = (slot_idx_q == IW'(i));
    end

    assign w_req_own    = |(req & w_owner);
    assign w_slot_end   = (slot_cnt_q == '0);
    assign w_beat_hit   = (|gnt_q) & beat;
    assign w_beat_total = beat_cnt_q + LW'(w_beat_hit);
    assign w_hit_max    = (w_beat_total == LEN_MAX);
    assign w_idx_next   = (slot_idx_q == IDX_LAST) ? '0 : slot_idx_q + IW'(1);

    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        slot_idx_d    = slot_idx_q;
        beat_cnt_d    = beat_cnt_q;
        gnt_d         = '0;
        slot_start_d  = slot_start_q;
        burst_done_d  = 1'b0;
        burst_len_d   = burst_len_q;
        burst_trunc_d = burst_trunc_q;

        if (en) begin
            if (w_slot_end) begin
                slot_cnt_d = CNT_RELOAD;
                slot_idx_d = w_idx_next;
                state_d    = ST_FIRST;
            end else begin
                slot_cnt_d = slot_cnt_q - CW'(1);
            end

            case (state_q)
                ST_GUARD: begin
                    if (slot_cnt_d == CNT_ARM) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_req_own) begin
                        state_d    = ST_BURST;
                        gnt_d      = w_owner;
                        beat_cnt_d = '0;
                    end else begin
`ifdef TDM_SKIP_IDLE_EN
                        slot_cnt_d = CNT_RELOAD;
                        slot_idx_d = w_idx_next;
                        state_d    = ST_FIRST;
`else
                        state_d    = ST_DONE;
`endif
                    end
                end
                ST_BURST: begin
                    beat_cnt_d = w_beat_total;
                    // Beat limit and request drop outrank the slot boundary.
                    if (w_hit_max || !w_req_own || w_slot_end) begin
                        burst_done_d  = 1'b1;
                        burst_len_d   = w_beat_total;
                        burst_trunc_d = !w_hit_max && w_req_own;
                        beat_cnt_d    = '0;
                        if (!w_slot_end) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        gnt_d = w_owner;
                    end
                end
                default: ;
            endcase

            slot_start_d = (slot_cnt_d == CNT_RELOAD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FIRST;
            slot_cnt_q    <= CNT_RELOAD;
            slot_idx_q    <= '0;
            beat_cnt_q    <= '0;
            gnt_q         <= '0;
            slot_start_q  <= 1'b1;
            burst_done_q  <= 1'b0;
            burst_len_q   <= '0;
            burst_trunc_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            slot_idx_q    <= slot_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            gnt_q         <= gnt_d;
            slot_start_q  <= slot_start_d;
            burst_done_q  <= burst_done_d;
            burst_len_q   <= burst_len_d;
            burst_trunc_q <= burst_trunc_d;
        end
    end

    assign gnt         = gnt_q;
    assign slot_idx    = slot_idx_q;
    assign slot_start  = slot_start_q;
    assign burst_done  = burst_done_q;
    assign burst_len   = burst_len_q;
    assign burst_trunc = burst_trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_burst_scheduler.sv
//==============================================================================
// Module : tb_tdm_burst_scheduler
// Brief  : Directed scenarios plus random traffic against a slot-level model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_tdm_burst_scheduler;

    localparam int NUM_CH    = 4;
    localparam int SLOT_LEN  = 15;
    localparam int BURST_MAX = 4;
    localparam int GUARD     = 2;
`ifdef TDM_SKIP_IDLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int IDLE_CYC = SKIP ? GUARD : SLOT_LEN + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       beat;
    logic [3:0] gnt;
    logic [1:0] slot_idx;
    logic       slot_start;
    logic       burst_done;
    logic [2:0] burst_len;
    logic       burst_trunc;

    int n_cmp = 0;
    int n_err = 0;
    int n_gnt, n_done, n_start, n_both;

    // Reference model: slot cycle number, owner, and whether a grant window is open.
    int         m_c, m_owner, m_beats, m_len;
    bit         m_active, m_trunc, m_done, m_start;
    logic [3:0] m_gnt;

    tdm_burst_scheduler #(
        .NUM_CH(NUM_CH), .SLOT_LEN(SLOT_LEN), .BURST_MAX(BURST_MAX), .GUARD(GUARD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .beat(beat),
        .gnt(gnt), .slot_idx(slot_idx), .slot_start(slot_start),
        .burst_done(burst_done), .burst_len(burst_len), .burst_trunc(burst_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_owner = 0; m_beats = 0; m_len = 0;
        m_active = 1'b0; m_trunc = 1'b0; m_done = 1'b0; m_start = 1'b1;
        m_gnt = 4'd0;
    endtask

    task automatic model_step();
        bit a, b, cc, done;
        done = 1'b0;
        if (!en) begin
            m_gnt  = 4'd0;
            m_done = 1'b0;
            return;
        end
        if (m_active) begin
            if (m_gnt != 4'd0 && beat) m_beats++;
            a  = (m_beats == BURST_MAX);
            b  = !req[m_owner];
            cc = (m_c == SLOT_LEN);
            if (a || b || cc) begin
                m_active = 1'b0;
                done     = 1'b1;
                m_len    = m_beats;
                m_trunc  = cc && !a && !b;
            end
        end else if (m_c == GUARD - 1) begin
            if (req[m_owner]) begin
                m_active = 1'b1;
                m_beats  = 0;
            end else if (SKIP) begin
                m_c = SLOT_LEN;
            end
        end
        if (m_c == SLOT_LEN) begin
            m_c     = 0;
            m_owner = (m_owner + 1) % NUM_CH;
        end else begin
            m_c++;
        end
        m_gnt   = m_active ? 4'(1 << m_owner) : 4'd0;
        m_done  = done;
        m_start = (m_c == 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt",         32'(gnt),         32'(m_gnt));
        chk("slot_idx",    32'(slot_idx),    32'(m_owner));
        chk("slot_start",  32'(slot_start),  32'(m_start));
        chk("burst_done",  32'(burst_done),  32'(m_done));
        chk("burst_len",   32'(burst_len),   32'(m_len));
        chk("burst_trunc", 32'(burst_trunc), 32'(m_trunc));
        if (gnt != 4'd0) n_gnt++;
        if (burst_done)  n_done++;
        if (slot_start)  n_start++;
        if (burst_done && slot_start) n_both++;
    endtask

    task automatic clr();
        n_gnt = 0; n_done = 0; n_start = 0; n_both = 0;
    endtask

    task automatic run_to_slot(input int owner);
        int k;
        for (k = 0; k < 200; k++) begin
            cyc();
            if (m_owner == owner && m_c == 0) break;
        end
        chk("run_to_slot_bound", 32'(k < 200), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b1; req = 4'd0; beat = 1'b0;
        model_reset();
        #2;
        chk("rst_gnt",         32'(gnt),         32'd0);
        chk("rst_slot_idx",    32'(slot_idx),    32'd0);
        chk("rst_slot_start",  32'(slot_start),  32'd1);
        chk("rst_burst_done",  32'(burst_done),  32'd0);
        chk("rst_burst_len",   32'(burst_len),   32'd0);
        chk("rst_burst_trunc", 32'(burst_trunc), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle frame: slot rotation only.
        clr();
        repeat (64) cyc();
        chk("sc1_starts", 32'(n_start), 32'(64 / IDLE_CYC));
        chk("sc1_gnt",    32'(n_gnt),   32'd0);
        chk("sc1_done",   32'(n_done),  32'd0);

        // Full-length burst on channel 1.
        clr();
        req = 4'b0010; beat = 1'b1;
        run_to_slot(2);
        chk("sc2_gnt_cycles", 32'(n_gnt),       32'd4);
        chk("sc2_done",       32'(n_done),      32'd1);
        chk("sc2_len",        32'(burst_len),   32'd4);
        chk("sc2_trunc",      32'(burst_trunc), 32'd0);

        // Channel 2 drops request after two beats, reasserts late in the slot.
        clr();
        for (k = 0; k < 200; k++) begin
            req  = (m_c < 4 || m_c >= 10) ? 4'b0100 : 4'b0000;
            beat = (m_c < 4);
            cyc();
            if (m_owner == 3 && m_c == 0) break;
        end
        chk("sc3_bound",      32'(k < 200),     32'd1);
        chk("sc3_gnt_cycles", 32'(n_gnt),       32'd3);
        chk("sc3_done",       32'(n_done),      32'd1);
        chk("sc3_len",        32'(burst_len),   32'd2);
        chk("sc3_trunc",      32'(burst_trunc), 32'd0);

        // Channel 3 holds request without beats: truncated at slot end.
        clr();
        req = 4'b1000; beat = 1'b0;
        run_to_slot(0);
        chk("sc4_gnt_cycles", 32'(n_gnt),       32'd14);
        chk("sc4_done_start", 32'(n_both),      32'd1);
        chk("sc4_len",        32'(burst_len),   32'd0);
        chk("sc4_trunc",      32'(burst_trunc), 32'd1);

        // Asynchronous reset in the middle of a slot-1 burst.
        req = 4'b0010; beat = 1'b1;
        for (k = 0; k < 200; k++) begin
            cyc();
            if (m_owner == 1 && m_c == 3) break;
        end
        chk("sc6_bound",  32'(k < 200), 32'd1);
        chk("sc6_pre_gnt", 32'(gnt),    32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("sc6_async_gnt",        32'(gnt),        32'd0);
        chk("sc6_async_slot_idx",   32'(slot_idx),   32'd0);
        chk("sc6_async_burst_done", 32'(burst_done), 32'd0);
        chk("sc6_async_slot_start", 32'(slot_start), 32'd1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clr();
        for (k = 0; k < 60; k++) begin
            cyc();
            if (gnt != 4'd0) break;
        end
        chk("sc6_first_gnt_cycle", 32'(k + 1), 32'(IDLE_CYC + GUARD));
        chk("sc6_first_gnt",       32'(gnt),   32'b0010);
        chk("sc6_no_done",         32'(n_done), 32'd0);

        // Random traffic with enable pauses.
        req = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            beat = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
